// File: rtl/project_alu.sv
// 64-bit registered ALU: arithmetic, logic, rotate/shift-by-one and compare; result valid one clock later.
// Define ALU_DIVIDER_EN to build the DIV/MOD divider; otherwise those opcodes return zero.
module project_alu (
   input  logic         clk,
   input  logic         rst,
   input  logic [63:0]  a,
   input  logic [63:0]  b,
   input  logic [4:0]   sel,
   output logic [127:0] c
);

   typedef enum logic [4:0] {
      OP_ADD  = 5'b00000,
      OP_SUB  = 5'b00001,
      OP_MUL  = 5'b00010,
      OP_DIV  = 5'b00011,
      OP_MOD  = 5'b00100,
      OP_OR   = 5'b00101,
      OP_AND  = 5'b00110,
      OP_NOTA = 5'b00111,
      OP_NOTB = 5'b01000,
      OP_XOR  = 5'b01001,
      OP_XNOR = 5'b01010,
      OP_NAND = 5'b01011,
      OP_NOR  = 5'b01100,
      OP_ROLA = 5'b01101,
      OP_RORA = 5'b01110,
      OP_ROLB = 5'b01111,
      OP_RORB = 5'b10000,
      OP_SHLA = 5'b10001,
      OP_SHRA = 5'b10010,
      OP_SHLB = 5'b10011,
      OP_SHRB = 5'b10100,
      OP_GT   = 5'b10101,
      OP_EQ   = 5'b10110
   } op_e;

   logic [127:0] r_c;
   logic [127:0] w_result;
   logic [64:0]  w_sum;
   logic [64:0]  w_diff;
   logic [127:0] w_prod;
   logic [63:0]  w_quot;
   logic [63:0]  w_rem;

   // Widening to 65 bits makes bit 64 the carry for ADD and the borrow for SUB.
   assign w_sum  = {1'b0, a} + {1'b0, b};
   assign w_diff = {1'b0, a} - {1'b0, b};
   assign w_prod = {64'd0, a} * {64'd0, b};

`ifdef ALU_DIVIDER_EN
   assign w_quot = (b == 64'd0) ? {64{1'b1}} : a / b;
   assign w_rem  = (b == 64'd0) ? a : a % b;
`else
   assign w_quot = 64'd0;
   assign w_rem  = 64'd0;
`endif

   always_comb begin
      w_result = 128'd0;
      case (sel)
         OP_ADD:  w_result = {63'd0, w_sum};
         OP_SUB:  w_result = {63'd0, w_diff};
         OP_MUL:  w_result = w_prod;
         OP_DIV:  w_result = {64'd0, w_quot};
         OP_MOD:  w_result = {64'd0, w_rem};
         OP_OR:   w_result = {64'd0, a | b};
         OP_AND:  w_result = {64'd0, a & b};
         OP_NOTA: w_result = {64'd0, ~a};
         OP_NOTB: w_result = {64'd0, ~b};
         OP_XOR:  w_result = {64'd0, a ^ b};
         OP_XNOR: w_result = {64'd0, ~(a ^ b)};
         OP_NAND: w_result = {64'd0, ~(a & b)};
         OP_NOR:  w_result = {64'd0, ~(a | b)};
         OP_ROLA: w_result = {64'd0, a[62:0], a[63]};
         OP_RORA: w_result = {64'd0, a[0], a[63:1]};
         OP_ROLB: w_result = {64'd0, b[62:0], b[63]};
         OP_RORB: w_result = {64'd0, b[0], b[63:1]};
         OP_SHLA: w_result = {64'd0, a[62:0], 1'b0};
         OP_SHRA: w_result = {64'd0, 1'b0, a[63:1]};
         OP_SHLB: w_result = {64'd0, b[62:0], 1'b0};
         OP_SHRB: w_result = {64'd0, 1'b0, b[63:1]};
         OP_GT:   w_result = {127'd0, a > b};
         OP_EQ:   w_result = {127'd0, a == b};
         default: w_result = 128'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_c <= 128'd0;
      end else begin
         r_c <= w_result;
      end
   end

   assign c = r_c;

endmodule

// File: tb/tb_project_alu.sv
// Directed-vector bench for project_alu; expected values are hand-computed constants.
// DIV/MOD expectations follow ALU_DIVIDER_EN.
module tb_project_alu;

   logic         clk = 1'b0;
   logic         rst;
   logic [63:0]  a;
   logic [63:0]  b;
   logic [4:0]   sel;
   logic [127:0] c;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   project_alu dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .sel (sel),
      .c   (c)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   // Drive one operation, let one edge pass, compare the registered result.
   task automatic run_op(input string tag, input logic r, input logic [63:0] va,
                         input logic [63:0] vb, input logic [4:0] vs, input logic [127:0] exp);
      rst = r;
      a   = va;
      b   = vb;
      sel = vs;
      @(posedge clk);
      #1;
      check(tag, c, exp);
   endtask

   initial begin
      rst = 1'b1;
      a   = 64'd0;
      b   = 64'd0;
      sel = 5'd0;
      #1;

      run_op("reset", 1'b1, 64'd100, 64'd50, 5'b00000, 128'd0);
      run_op("add_100_50", 1'b0, 64'd100, 64'd50, 5'b00000, 128'd150);
      run_op("add_carry", 1'b0, ONES, 64'd1, 5'b00000, {64'd1, 64'd0});
      run_op("sub_200_75", 1'b0, 64'd200, 64'd75, 5'b00001, 128'd125);
      run_op("sub_borrow", 1'b0, 64'd75, 64'd200, 5'b00001, {64'd1, 64'hFFFF_FFFF_FFFF_FF83});
      run_op("mul_x2", 1'b0, ONES, 64'd2, 5'b00010, {64'd1, 64'hFFFF_FFFF_FFFF_FFFE});
      run_op("mul_full", 1'b0, ONES, ONES, 5'b00010, {64'hFFFF_FFFF_FFFF_FFFE, 64'd1});
`ifdef ALU_DIVIDER_EN
      run_op("div_500_500", 1'b0, 64'd500, 64'd500, 5'b00011, 128'd1);
      run_op("mod_500_7", 1'b0, 64'd500, 64'd7, 5'b00100, 128'd3);
      run_op("div_by_0", 1'b0, 64'd500, 64'd0, 5'b00011, {64'd0, ONES});
      run_op("mod_by_0", 1'b0, 64'd500, 64'd0, 5'b00100, 128'd500);
`else
      run_op("div_off", 1'b0, 64'd500, 64'd500, 5'b00011, 128'd0);
      run_op("add_again", 1'b0, 64'd1, 64'd2, 5'b00000, 128'd3);
      run_op("mod_off", 1'b0, 64'd500, 64'd7, 5'b00100, 128'd0);
`endif
      run_op("rola", 1'b0, 64'h8000_0000_0000_0001, 64'd0, 5'b01101, 128'd3);
      run_op("rora", 1'b0, 64'h8000_0000_0000_0001, 64'd0, 5'b01110, {64'd0, 64'hC000_0000_0000_0000});
      run_op("shla", 1'b0, 64'h8000_0000_0000_0001, 64'd0, 5'b10001, 128'd2);
      run_op("shra", 1'b0, 64'h8000_0000_0000_0001, 64'd0, 5'b10010, {64'd0, 64'h4000_0000_0000_0000});
      run_op("rolb", 1'b0, 64'd0, 64'h8000_0000_0000_0001, 5'b01111, 128'd3);
      run_op("rorb", 1'b0, 64'd0, 64'h8000_0000_0000_0001, 5'b10000, {64'd0, 64'hC000_0000_0000_0000});
      run_op("shlb", 1'b0, 64'd0, 64'h8000_0000_0000_0001, 5'b10011, 128'd2);
      run_op("shrb", 1'b0, 64'd0, 64'h8000_0000_0000_0001, 5'b10100, {64'd0, 64'h4000_0000_0000_0000});
      run_op("or", 1'b0, ONES, 64'd1, 5'b00101, {64'd0, ONES});
      run_op("and", 1'b0, ONES, 64'd1, 5'b00110, 128'd1);
      run_op("nand", 1'b0, ONES, 64'd1, 5'b01011, {64'd0, 64'hFFFF_FFFF_FFFF_FFFE});
      run_op("gt_true", 1'b0, ONES, 64'd1, 5'b10101, 128'd1);
      run_op("eq_false", 1'b0, ONES, 64'd1, 5'b10110, 128'd0);
      run_op("eq_true", 1'b0, 64'd1234, 64'd1234, 5'b10110, 128'd1);
      run_op("gt_false", 1'b0, 64'd5, 64'd9, 5'b10101, 128'd0);
      run_op("xor", 1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 5'b01001, {64'd0, 64'h0FF0_0FF0_0FF0_0FF0});
      run_op("xnor", 1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 5'b01010, {64'd0, 64'hF00F_F00F_F00F_F00F});
      run_op("nor", 1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 5'b01100, {64'd0, 64'h000F_000F_000F_000F});
      run_op("nota", 1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 5'b00111, {64'd0, 64'h0F0F_0F0F_0F0F_0F0F});
      run_op("notb", 1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 5'b01000, {64'd0, 64'h00FF_00FF_00FF_00FF});
      run_op("reserved_1f", 1'b0, ONES, 64'd1, 5'b11111, 128'd0);
      run_op("add_pre", 1'b0, 64'd7, 64'd8, 5'b00000, 128'd15);
      run_op("reserved_17", 1'b0, ONES, 64'd1, 5'b10111, 128'd0);

      // Reset issued together with a MUL discards it.
      run_op("mul_pre", 1'b0, 64'd3, 64'd5, 5'b00010, 128'd15);
      run_op("rst_with_mul", 1'b1, ONES, ONES, 5'b00010, 128'd0);

      // Back-to-back: new inputs must not affect c until the next edge.
      rst = 1'b0;
      a   = 64'd10;
      b   = 64'd20;
      sel = 5'b00000;
      #2;
      check("hold_before_edge", c, 128'd0);
      @(posedge clk);
      #1;
      check("b2b_add", c, 128'd30);
      a   = 64'd6;
      b   = 64'd7;
      sel = 5'b00010;
      #2;
      check("hold_add", c, 128'd30);
      @(posedge clk);
      #1;
      check("b2b_mul", c, 128'd42);
      run_op("b2b_sub", 1'b0, 64'd9, 64'd4, 5'b00001, 128'd5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
